// File: rtl/tri_vertex_serializer.sv
// Triangle FIFO fed by the vertex_calc valid/stall handshake; replays each
// stored triangle to raster setup as three vertex beats over valid/ready.
module tri_vertex_serializer #(
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0][31:0] in_x,
    input  logic [3:0][31:0] in_y,
    input  logic [3:0][31:0] in_z,
    input  logic [3:0][31:0] in_w,
    input  logic [23:0]      in_color1,
    input  logic [23:0]      in_color2,
    input  logic [23:0]      in_color3,
    input  logic             in_valid,
    input  logic             in_done,
    output logic             stall_out,
    output logic             vtx_valid,
    input  logic             vtx_ready,
    output logic [31:0]      vtx_x,
    output logic [31:0]      vtx_y,
    output logic [31:0]      vtx_z,
    output logic [23:0]      vtx_color,
    output logic [1:0]       vtx_idx,
    output logic             vtx_last,
    output logic             vtx_done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    typedef struct packed {
        logic [2:0][31:0] x;
        logic [2:0][31:0] y;
        logic [2:0][31:0] z;
        logic [2:0][23:0] c;
        logic             done;
    } tri_t;

    typedef enum logic [1:0] {S_IDLE, S_V0, S_V1, S_V2} state_t;

    tri_t          mem [DEPTH];
    tri_t          wr_data;
    tri_t          head;
    tri_t          nxt;
    tri_t          ld_tri;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nx;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          armed;
    logic          push;
    logic          pop;
    logic          load;
    logic [1:0]    ld_idx;
    state_t        state;

    // w and the fourth vertex slot are not forwarded downstream
    logic unused_in;
    assign unused_in = ^{in_w, in_x[3], in_y[3], in_z[3]};

    assign wr_data.x    = in_x[2:0];
    assign wr_data.y    = in_y[2:0];
    assign wr_data.z    = in_z[2:0];
    assign wr_data.c    = {in_color3, in_color2, in_color1};
    assign wr_data.done = in_done;

    assign push       = in_valid & armed & ~stall_out;
    assign pop        = vtx_valid & vtx_ready & (state == S_V2);
    assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    assign rd_ptr_nx  = rd_ptr + AW'(1);
    assign head       = mem[rd_ptr];
    assign nxt        = mem[rd_ptr_nx];

    // Next beat source; a same-cycle push never counts as readable
    always_comb begin
        load   = 1'b0;
        ld_tri = head;
        ld_idx = 2'd0;
        unique case (state)
            S_IDLE: load = (count != '0);
            S_V0: begin
                load   = vtx_ready;
                ld_idx = 2'd1;
            end
            S_V1: begin
                load   = vtx_ready;
                ld_idx = 2'd2;
            end
            S_V2: begin
                load   = vtx_ready & (count > ONE);
                ld_tri = nxt;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            stall_out <= 1'b0;
            armed     <= 1'b1;
            state     <= S_IDLE;
            vtx_valid <= 1'b0;
            vtx_x     <= '0;
            vtx_y     <= '0;
            vtx_z     <= '0;
            vtx_color <= '0;
            vtx_idx   <= '0;
            vtx_last  <= 1'b0;
            vtx_done  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nx;
            end
            count     <= count_next;
            stall_out <= (count_next == FULL);

            if (push) begin
                armed <= 1'b0;
            end else if (!in_valid) begin
                armed <= 1'b1;
            end

            if (load) begin
                vtx_valid <= 1'b1;
                vtx_x     <= ld_tri.x[ld_idx];
                vtx_y     <= ld_tri.y[ld_idx];
                vtx_z     <= ld_tri.z[ld_idx];
                vtx_color <= ld_tri.c[ld_idx];
                vtx_idx   <= ld_idx;
                vtx_last  <= (ld_idx == 2'd2);
                vtx_done  <= (ld_idx == 2'd2) & ld_tri.done;
            end

            unique case (state)
                S_IDLE: if (load) state <= S_V0;
                S_V0:   if (vtx_ready) state <= S_V1;
                S_V1:   if (vtx_ready) state <= S_V2;
                S_V2: begin
                    if (vtx_ready) begin
                        if (load) begin
                            state <= S_V0;
                        end else begin
                            state     <= S_IDLE;
                            vtx_valid <= 1'b0;
                            vtx_idx   <= '0;
                            vtx_last  <= 1'b0;
                            vtx_done  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
